// File: rtl/mipi_lane_aligner_if.sv
// Bus bundle for the multi-lane MIPI word aligner. The deserialiser side
// (master) drives raw lane words, LP pin states and static configuration.
// The aligner (slave) returns merged, deskewed lane words and status.
interface mipi_lane_aligner_if #(
  parameter int NUM_LANES = 2
);
  logic [8*NUM_LANES-1:0] q_in;
  logic [NUM_LANES-1:0]   lp_p;
  logic [NUM_LANES-1:0]   lp_n;
  logic [NUM_LANES-1:0]   lane_polarity;
  logic [7:0]             hs_settle;
  logic [8*NUM_LANES-1:0] data;
  logic                   we;
  logic                   sync_err;
  logic [3*NUM_LANES-1:0] lane_sync_pos;
  logic [1:0]             state;

  modport master (
    output q_in, lp_p, lp_n, lane_polarity, hs_settle,
    input  data, we, sync_err, lane_sync_pos, state
  );

  modport slave (
    input  q_in, lp_p, lp_n, lane_polarity, hs_settle,
    output data, we, sync_err, lane_sync_pos, state
  );
endinterface

// File: rtl/mipi_lane_aligner.sv
// Multi-lane MIPI HS word aligner: per-lane HS entry detection, sync byte bit
// alignment, then cross-lane byte deskew through small per-lane FIFOs.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_START | LP mode; count consecutive all-lane LP00 cycles up to hs_settle
// ST_SYNC  | search each unlocked lane for SYNC_BYTE, locked lanes fill FIFO
// ST_SHIFT | all lanes locked; pop one byte per lane per cycle onto data
// ST_ABORT | deskew timed out; wait for LP11 on every lane
module mipi_lane_aligner #(
  parameter int         NUM_LANES    = 2,
  parameter logic [7:0] SYNC_BYTE    = 8'hB8,
  parameter int         DESKEW_DEPTH = 4
) (
  input logic                clk,
  input logic                resetb,
  mipi_lane_aligner_if.slave bus
);
  // DESKEW_DEPTH is a power of two of at least 2, so pointers wrap naturally.
  localparam int AW = $clog2(DESKEW_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_SYNC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      run_q;
  logic [NUM_LANES-1:0]      lp_p_s_q, lp_n_s_q;
  logic [NUM_LANES-1:0][7:0] q0_q, q1_q;
  logic [7:0]                settle_q, settle_d;
  logic [NUM_LANES-1:0]      lock_q, lock_d;
  logic [NUM_LANES-1:0][2:0] pos_q, pos_d;
  logic [CW-1:0]             skew_q, skew_d;
  logic [NUM_LANES-1:0][7:0] data_q, data_d;
  logic                      we_q, we_d;
  logic                      sync_err_q, sync_err_d;

  logic [7:0]                 mem_q [NUM_LANES][DESKEW_DEPTH];
  logic [NUM_LANES-1:0][AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NUM_LANES-1:0][CW-1:0] cnt_q;

  logic                       all_lp00, all_lp11, all_nonempty, flush, pop;
  logic [NUM_LANES-1:0]       push, hit;
  logic [NUM_LANES-1:0][2:0]  hit_pos;
  logic [NUM_LANES-1:0][15:0] win;
  logic [NUM_LANES-1:0][7:0]  push_byte, head_byte;

  assign all_lp00 = ~|(lp_p_s_q | lp_n_s_q);
  assign all_lp11 = &(lp_p_s_q & lp_n_s_q);

  // Reset release synchroniser: logic runs from the 2nd edge after deassertion.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  // Per-lane window compare, smallest matching shift wins; FIFO head and push byte.
  always_comb begin
    all_nonempty = 1'b1;
    for (int n = 0; n < NUM_LANES; n++) begin
      win[n]     = {q0_q[n], q1_q[n]} ^ {16{bus.lane_polarity[n]}};
      hit[n]     = 1'b0;
      hit_pos[n] = 3'd0;
      for (int s = 7; s >= 0; s--) begin
        if (8'(win[n] >> (8 - s)) == SYNC_BYTE) begin
          hit[n]     = 1'b1;
          hit_pos[n] = 3'(s);
        end
      end
      push_byte[n] = 8'(win[n] >> (4'd8 - {1'b0, pos_q[n]}));
      head_byte[n] = mem_q[n][rd_ptr_q[n]];
      if (cnt_q[n] == '0) all_nonempty = 1'b0;
    end
  end

  // Next-state and output decode for the sequencing FSM.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    lock_d     = lock_q;
    pos_d      = pos_q;
    skew_d     = skew_q;
    data_d     = data_q;
    we_d       = 1'b0;
    sync_err_d = 1'b0;
    flush      = 1'b0;
    pop        = 1'b0;
    push       = '0;
    case (state_q)
      ST_START: begin
        flush = 1'b1;
        if (all_lp00) begin
          if (settle_q >= bus.hs_settle) begin
            state_d  = ST_SYNC;
            settle_d = 8'd0;
            lock_d   = '0;
            skew_d   = '0;
          end else if (settle_q != 8'hFF) begin
            settle_d = settle_q + 8'd1;
          end
        end else begin
          settle_d = 8'd0;
        end
      end
      ST_SYNC: begin
        if (!all_lp00) begin
          state_d = ST_START;
          flush   = 1'b1;
        end else if ((|lock_q) && !(&lock_q) &&
                     ((int'(skew_q) + 1) >= DESKEW_DEPTH)) begin
          // Timeout wins over a lock arriving on the same cycle.
          sync_err_d = 1'b1;
          state_d    = ST_ABORT;
          flush      = 1'b1;
        end else begin
          push = lock_q;
          for (int n = 0; n < NUM_LANES; n++) begin
            if (!lock_q[n] && hit[n]) begin
              lock_d[n] = 1'b1;
              pos_d[n]  = hit_pos[n];
            end
          end
          if (|lock_q) skew_d = skew_q + CW'(1);
          if (&lock_d) state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!all_lp00) begin
          state_d = ST_START;
          flush   = 1'b1;
        end else begin
          push = lock_q;
          if (all_nonempty) begin
            pop    = 1'b1;
            we_d   = 1'b1;
            data_d = head_byte;
          end
        end
      end
      ST_ABORT: begin
        flush = 1'b1;
        if (all_lp11) state_d = ST_START;
      end
      default: state_d = ST_START;
    endcase
  end

  // Control, LP synchroniser, window and output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= ST_START;
      lp_p_s_q   <= '1;
      lp_n_s_q   <= '1;
      q0_q       <= '0;
      q1_q       <= '0;
      settle_q   <= 8'd0;
      lock_q     <= '0;
      pos_q      <= '0;
      skew_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      sync_err_q <= 1'b0;
    end else if (run_q) begin
      state_q    <= state_d;
      lp_p_s_q   <= bus.lp_p;
      lp_n_s_q   <= bus.lp_n;
      q0_q       <= bus.q_in;
      q1_q       <= q0_q;
      settle_q   <= settle_d;
      lock_q     <= lock_d;
      pos_q      <= pos_d;
      skew_q     <= skew_d;
      data_q     <= data_d;
      we_q       <= we_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Deskew FIFO pointers and occupancy; flush empties every lane at once.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (run_q) begin
      for (int n = 0; n < NUM_LANES; n++) begin
        if (flush) begin
          wr_ptr_q[n] <= '0;
          rd_ptr_q[n] <= '0;
          cnt_q[n]    <= '0;
        end else begin
          if (push[n]) wr_ptr_q[n] <= wr_ptr_q[n] + AW'(1);
          if (pop)     rd_ptr_q[n] <= rd_ptr_q[n] + AW'(1);
          cnt_q[n] <= cnt_q[n] + CW'(push[n]) - CW'(pop);
        end
      end
    end
  end

  // Deskew FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_LANES; n++) begin
      if (run_q && push[n]) mem_q[n][wr_ptr_q[n]] <= push_byte[n];
    end
  end

  assign bus.data          = data_q;
  assign bus.we            = we_q;
  assign bus.sync_err      = sync_err_q;
  assign bus.lane_sync_pos = pos_q;
  assign bus.state         = state_q;
endmodule

// File: tb/tb_mipi_lane_aligner.sv
// Directed bench for mipi_lane_aligner (2 lanes, depth 4). Stimulus tasks
// queue the expected merged words; a monitor pops them whenever we is high.
module tb_mipi_lane_aligner;
  logic clk;
  logic resetb;
  int   checks     = 0;
  int   failures   = 0;
  int   err_pulses = 0;
  logic [15:0] sb_q[$];

  mipi_lane_aligner_if #(.NUM_LANES(2)) bus ();

  mipi_lane_aligner #(
    .NUM_LANES(2), .SYNC_BYTE(8'hB8), .DESKEW_DEPTH(4)
  ) dut (
    .clk(clk), .resetb(resetb), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Raw deserialiser word that puts byte 'cur' at bit offset s in the window.
  function automatic logic [7:0] lane_word(input logic [7:0] cur, input logic [7:0] nxt, input int s);
    logic [15:0] w;
    w = {nxt, cur} >> s;
    return w[7:0];
  endfunction

  // Monitor: every valid word must match the head of the expected queue.
  initial begin
    logic [15:0] exp_w;
    forever begin
      @(negedge clk);
      if (resetb === 1'b1 && bus.we === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_we actual=%h required=no_word", bus.data);
        end else begin
          exp_w = sb_q.pop_front();
          if (bus.data !== exp_w) begin
            failures++;
            $display("FAIL data_word actual=%h required=%h", bus.data, exp_w);
          end
        end
      end
      if (bus.sync_err === 1'b1) err_pulses++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  // One HS burst: settle, sync at per-lane index t0 and shift s, np payload
  // bytes, then leave HS (LP11 on all lanes, or only lane0 lp_p high).
  task automatic run_burst(input string tag, input logic [7:0] settle,
                           input int t0a, input int t0b, input int sa, input int sb,
                           input logic [1:0] pol, input logic [31:0] pa, input logic [31:0] pb,
                           input int np, input bit exp_err, input bit end_lp0);
    logic [7:0] ba [0:15];
    logic [7:0] bb [0:15];
    int n, tl, tt, err0;
    for (int i = 0; i < 16; i++) begin ba[i] = 8'h00; bb[i] = 8'h00; end
    ba[t0a] = 8'hB8;
    bb[t0b] = 8'hB8;
    for (int k = 0; k < np; k++) begin
      ba[t0a+1+k] = pa[8*k +: 8];
      bb[t0b+1+k] = pb[8*k +: 8];
    end
    bus.lane_polarity = pol;
    bus.hs_settle     = settle;
    @(posedge clk); #1;
    bus.lp_p = 2'b00;
    bus.lp_n = 2'b00;
    bus.q_in = {{8{pol[1]}}, {8{pol[0]}}};
    n = 0;
    while (bus.state !== 2'd1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_settle_cycles"}, n, 32'(settle) + 32'd3);
    err0 = err_pulses;
    tl = (t0a > t0b) ? t0a : t0b;
    tt = tl + 2 + np;
    if (!exp_err)
      for (int k = 0; k < np; k++) sb_q.push_back({pb[8*k +: 8], pa[8*k +: 8]});
    for (int t = 0; t < tt; t++) begin
      @(posedge clk); #1;
      bus.q_in = {lane_word(bb[t], bb[t+1], sb) ^ {8{pol[1]}},
                  lane_word(ba[t], ba[t+1], sa) ^ {8{pol[0]}}};
    end
    @(negedge clk);
    check({tag, "_state_hs"}, bus.state, exp_err ? 32'd3 : 32'd2);
    check({tag, "_pos_lane0"}, bus.lane_sync_pos[2:0], 32'(sa));
    if (!exp_err) check({tag, "_pos_lane1"}, bus.lane_sync_pos[5:3], 32'(sb));
    @(posedge clk); #1;
    if (end_lp0) bus.lp_p[0] = 1'b1;
    else begin bus.lp_p = 2'b11; bus.lp_n = 2'b11; end
    bus.q_in = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_we_after_1_edge"}, bus.we, exp_err ? 32'd0 : 32'd1);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_we_after_2_edges"}, bus.we, 32'd0);
    check({tag, "_state_end"}, bus.state, 32'd0);
    check({tag, "_queue_drained"}, sb_q.size(), 32'd0);
    check({tag, "_sync_err_pulses"}, err_pulses - err0, exp_err ? 32'd1 : 32'd0);
  endtask

  initial begin
    resetb            = 1'b0;
    bus.q_in          = 16'h0000;
    bus.lp_p          = 2'b11;
    bus.lp_n          = 2'b11;
    bus.lane_polarity = 2'b00;
    bus.hs_settle     = 8'd4;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", bus.state, 32'd0);
    check("rst_we", bus.we, 32'd0);
    check("rst_data", bus.data, 32'd0);
    check("rst_pos", bus.lane_sync_pos, 32'd0);
    check("rst_sync_err", bus.sync_err, 32'd0);
    resetb = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_state", bus.state, 32'd0);

    run_burst("same_skew",   8'd4, 0, 0, 0, 0, 2'b00, 32'h00332211, 32'h00332211, 3, 1'b0, 1'b0);
    run_burst("offset_3_6",  8'd4, 0, 1, 3, 6, 2'b00, 32'h00005AA5, 32'h00005AA5, 2, 1'b0, 1'b0);
    run_burst("polarity",    8'd4, 0, 0, 0, 0, 2'b10, 32'h0000C33C, 32'h00009669, 2, 1'b0, 1'b0);
    run_burst("skew_4_err",  8'd4, 0, 4, 0, 0, 2'b00, 32'h00002211, 32'h00004433, 2, 1'b1, 1'b0);
    run_burst("skew_3_ok",   8'd0, 0, 3, 0, 0, 2'b00, 32'h00008877, 32'h00003412, 2, 1'b0, 1'b0);
    run_burst("lp_exit",     8'd4, 0, 0, 0, 0, 2'b00, 32'h00030201, 32'h00F3F2F1, 3, 1'b0, 1'b1);
    run_burst("relock_5",    8'd4, 1, 1, 5, 5, 2'b00, 32'h00003412, 32'h00003412, 2, 1'b0, 1'b0);

    // Reset while streaming: two words out, then async reset clears everything.
    bus.lane_polarity = 2'b00;
    bus.hs_settle     = 8'd4;
    @(posedge clk); #1;
    bus.lp_p = 2'b00;
    bus.lp_n = 2'b00;
    begin
      int n;
      logic [15:0] words [0:5];
      n = 0;
      while (bus.state !== 2'd1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("rstmid_settle_cycles", n, 32'd7);
      words[0] = 16'hB8B8; words[1] = 16'hD1C1; words[2] = 16'hD2C2;
      words[3] = 16'hD3C3; words[4] = 16'hD4C4; words[5] = 16'h0000;
      sb_q.push_back(16'hD1C1);
      sb_q.push_back(16'hD2C2);
      for (int t = 0; t < 6; t++) begin
        @(posedge clk); #1;
        bus.q_in = words[t];
      end
    end
    @(negedge clk);
    check("rstmid_we_before", bus.we, 32'd1);
    check("rstmid_data_before", bus.data, 32'h0000D2C2);
    #1 resetb = 1'b0;
    #1;
    check("rstmid_state", bus.state, 32'd0);
    check("rstmid_we", bus.we, 32'd0);
    check("rstmid_data", bus.data, 32'd0);
    check("rstmid_pos", bus.lane_sync_pos, 32'd0);
    check("rstmid_sync_err", bus.sync_err, 32'd0);
    check("rstmid_queue", sb_q.size(), 32'd0);
    bus.lp_p = 2'b11;
    bus.lp_n = 2'b11;
    bus.q_in = 16'hB8B8;
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("post_rst_state", bus.state, 32'd0);
    check("post_rst_we", bus.we, 32'd0);
    bus.q_in = 16'h0000;

    run_burst("after_reset", 8'd2, 0, 0, 0, 0, 2'b00, 32'h0000E55E, 32'h0000A55A, 2, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
